// File: rtl/product_accumulator.sv
// product_accumulator: saturating signed MAC back end that sums a programmed number of products and returns the result over a valid/ready handshake
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 68,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] product,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, sat;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d, pos_ovf, neg_ovf;
  logic [ACC_W:0]     sum;
  assign prod_ready = en && state_q == ACCUM;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign acc_out    = acc_q;
  assign overflow   = ovf_q;
  // one extra bit of headroom exposes overflow as a mismatch of the top two sum bits
  always_comb begin
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
    pos_ovf = !sum[ACC_W] && sum[ACC_W-1];
    neg_ovf = sum[ACC_W] && !sum[ACC_W-1];
    sat     = pos_ovf ? {1'b0, {(ACC_W-1){1'b1}}} :
              neg_ovf ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];
  end
  // next-state: everything holds unless enabled
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    if (en) begin
      case (state_q)
        IDLE: if (start) begin
          rem_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
        ACCUM: if (prod_valid) begin
          acc_d   = sat;
          ovf_d   = ovf_q | pos_ovf | neg_ovf;
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? DONE : ACCUM;
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
